// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Purpose  : WISC pipeline memory stage. EX/MEM latch, multi-cycle data
//             memory handshake with timeout, and registered writeback bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        InValid,
    input  logic [15:0] AluResIn,
    input  logic [15:0] RtIn,
    input  logic        RegWriteIn,
    input  logic        DMemWriteIn,
    input  logic        DMemEnIn,
    input  logic        MemToRegIn,
    input  logic        DMemDumpIn,
    input  logic [2:0]  RdAddrIn,
    output logic        StallOut,
    output logic [15:0] MemAddr,
    output logic [15:0] MemDataIn,
    output logic        MemRd,
    output logic        MemWr,
    output logic        MemDump,
    input  logic        mem_done,
    input  logic [15:0] mem_data_out,
    output logic        WbValid,
    output logic [15:0] WbData,
    output logic        WbRegWrite,
    output logic [2:0]  WbRdAddr,
    output logic        Halt,
    output logic        Err
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_WAIT     = 2'd1;
    localparam logic [1:0]       c_HALT     = 2'd2;
    localparam logic [1:0]       c_ERR      = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_WAIT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        valid_q, valid_d;
    logic [15:0] alu_res_q, alu_res_d;
    logic [15:0] rt_q, rt_d;
    logic        reg_write_q, reg_write_d;
    logic        dmem_write_q, dmem_write_d;
    logic        dmem_en_q, dmem_en_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        dmem_dump_q, dmem_dump_d;
    logic [2:0]  rd_addr_q, rd_addr_d;

    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [2:0]  wb_rd_addr_q, wb_rd_addr_d;

    logic        w_stall;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_mem_dump;

    // State register and all pipeline flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= c_IDLE;
            cnt_q          <= '0;
            valid_q        <= 1'b0;
            alu_res_q      <= '0;
            rt_q           <= '0;
            reg_write_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_en_q      <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            dmem_dump_q    <= 1'b0;
            rd_addr_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_reg_write_q <= 1'b0;
            wb_rd_addr_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            valid_q        <= valid_d;
            alu_res_q      <= alu_res_d;
            rt_q           <= rt_d;
            reg_write_q    <= reg_write_d;
            dmem_write_q   <= dmem_write_d;
            dmem_en_q      <= dmem_en_d;
            mem_to_reg_q   <= mem_to_reg_d;
            dmem_dump_q    <= dmem_dump_d;
            rd_addr_q      <= rd_addr_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_addr_q   <= wb_rd_addr_d;
        end
    end

    // Next-state logic; dump outranks a memory access in the same bundle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (valid_q) begin
                    if (dmem_dump_q) begin
                        state_d = c_HALT;
                    end else if (dmem_en_q) begin
                        if (alu_res_q[0]) begin
                            state_d = c_ERR;
                        end else begin
                            state_d = c_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            c_WAIT: begin
                if (mem_done) begin
                    state_d = c_IDLE;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = c_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output logic: strobes only from IDLE, so each is a single cycle
    always_comb begin
        w_stall    = 1'b1;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_mem_dump = 1'b0;
        if (state_q == c_IDLE) begin
            w_stall    = valid_q & (dmem_dump_q | dmem_en_q);
            w_mem_dump = valid_q & dmem_dump_q;
            w_mem_rd   = valid_q & ~dmem_dump_q & dmem_en_q & ~alu_res_q[0] & ~dmem_write_q;
            w_mem_wr   = valid_q & ~dmem_dump_q & dmem_en_q & ~alu_res_q[0] & dmem_write_q;
        end
    end

    // EX/MEM latch capture and writeback bundle
    always_comb begin
        valid_d        = valid_q;
        alu_res_d      = alu_res_q;
        rt_d           = rt_q;
        reg_write_d    = reg_write_q;
        dmem_write_d   = dmem_write_q;
        dmem_en_d      = dmem_en_q;
        mem_to_reg_d   = mem_to_reg_q;
        dmem_dump_d    = dmem_dump_q;
        rd_addr_d      = rd_addr_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_addr_d   = wb_rd_addr_q;

        if (!w_stall) begin
            valid_d        = InValid;
            alu_res_d      = AluResIn;
            rt_d           = RtIn;
            reg_write_d    = RegWriteIn;
            dmem_write_d   = DMemWriteIn;
            dmem_en_d      = DMemEnIn;
            mem_to_reg_d   = MemToRegIn;
            dmem_dump_d    = DMemDumpIn;
            rd_addr_d      = RdAddrIn;
            wb_valid_d     = valid_q;
            wb_data_d      = alu_res_q;
            wb_reg_write_d = reg_write_q;
            wb_rd_addr_d   = rd_addr_q;
        end else if (state_q == c_WAIT && mem_done) begin
            valid_d        = 1'b0;
            wb_valid_d     = 1'b1;
            wb_data_d      = mem_to_reg_q ? mem_data_out : alu_res_q;
            wb_reg_write_d = reg_write_q;
            wb_rd_addr_d   = rd_addr_q;
        end
    end

    assign StallOut   = w_stall;
    assign MemRd      = w_mem_rd;
    assign MemWr      = w_mem_wr;
    assign MemDump    = w_mem_dump;
    assign MemAddr    = alu_res_q;
    assign MemDataIn  = rt_q;
    assign WbValid    = wb_valid_q;
    assign WbData     = wb_data_q;
    assign WbRegWrite = wb_valid_q & wb_reg_write_q;
    assign WbRdAddr   = wb_rd_addr_q;
    assign Halt       = (state_q == c_HALT);
    assign Err        = (state_q == c_ERR);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed scenarios followed
//             by randomized traffic against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid, RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn;
    logic [15:0] AluResIn, RtIn, mem_data_out;
    logic [2:0]  RdAddrIn;
    logic        mem_done;
    logic        StallOut, MemRd, MemWr, MemDump, WbValid, WbRegWrite, Halt, Err;
    logic [15:0] MemAddr, MemDataIn, WbData;
    logic [2:0]  WbRdAddr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one latched instruction plus a coarse activity status
    logic        m_valid;
    logic [15:0] m_alu, m_rt;
    logic        m_rw, m_wr, m_en, m_m2r, m_dump;
    logic [2:0]  m_rd;
    bit          m_waiting, m_halted, m_errored;
    int          m_waited;
    logic        m_wbv, m_wbrw;
    logic [15:0] m_wbd;
    logic [2:0]  m_wbrd;

    bit no_resp;

    mem_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .AluResIn(AluResIn), .RtIn(RtIn),
        .RegWriteIn(RegWriteIn), .DMemWriteIn(DMemWriteIn), .DMemEnIn(DMemEnIn),
        .MemToRegIn(MemToRegIn), .DMemDumpIn(DMemDumpIn), .RdAddrIn(RdAddrIn),
        .StallOut(StallOut), .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemRd(MemRd),
        .MemWr(MemWr), .MemDump(MemDump), .mem_done(mem_done), .mem_data_out(mem_data_out),
        .WbValid(WbValid), .WbData(WbData), .WbRegWrite(WbRegWrite), .WbRdAddr(WbRdAddr),
        .Halt(Halt), .Err(Err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_bundle(input logic v, input logic [15:0] alu, input logic [15:0] rt,
                              input logic rw, input logic wr, input logic en,
                              input logic m2r, input logic dump, input logic [2:0] rd);
        InValid = v; AluResIn = alu; RtIn = rt; RegWriteIn = rw; DMemWriteIn = wr;
        DMemEnIn = en; MemToRegIn = m2r; DMemDumpIn = dump; RdAddrIn = rd;
    endtask

    function automatic bit m_ready();
        return !m_waiting && !m_halted && !m_errored;
    endfunction

    function automatic bit m_stall();
        return !m_ready() || (m_valid && (m_dump || m_en));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_alu = '0; m_rt = '0; m_rw = 0; m_wr = 0; m_en = 0; m_m2r = 0;
        m_dump = 0; m_rd = '0; m_waiting = 0; m_halted = 0; m_errored = 0; m_waited = 0;
        m_wbv = 0; m_wbrw = 0; m_wbd = '0; m_wbrd = '0;
    endtask

    // Advance the model across one rising edge using the inputs now applied
    task automatic model_step();
        bit capture;
        if (rst) begin
            model_reset();
            return;
        end
        capture = !m_stall();
        m_wbv   = 0;
        if (m_waiting) begin
            if (mem_done) begin
                m_wbv = 1; m_wbd = m_m2r ? mem_data_out : m_alu;
                m_wbrw = m_rw; m_wbrd = m_rd;
                m_valid = 0; m_waiting = 0;
            end else if (m_waited == MAX_WAIT) begin
                m_waiting = 0; m_errored = 1;
            end else begin
                m_waited++;
            end
        end else if (m_ready()) begin
            if (m_valid && m_dump) begin
                m_halted = 1;
            end else if (m_valid && m_en) begin
                if (m_alu[0]) m_errored = 1;
                else begin
                    m_waiting = 1; m_waited = 0;
                    no_resp = ($urandom_range(0, 11) == 0);
                end
            end else begin
                m_wbv = m_valid; m_wbd = m_alu; m_wbrw = m_rw; m_wbrd = m_rd;
            end
        end
        if (capture) begin
            m_valid = InValid; m_alu = AluResIn; m_rt = RtIn; m_rw = RegWriteIn;
            m_wr = DMemWriteIn; m_en = DMemEnIn; m_m2r = MemToRegIn;
            m_dump = DMemDumpIn; m_rd = RdAddrIn;
        end
    endtask

    task automatic check_outputs();
        bit memop;
        memop = m_ready() && m_valid && !m_dump && m_en && !m_alu[0];
        check("stall",   16'(StallOut),   16'(m_stall()));
        check("memrd",   16'(MemRd),      16'(memop && !m_wr));
        check("memwr",   16'(MemWr),      16'(memop && m_wr));
        check("memdump", 16'(MemDump),    16'(m_ready() && m_valid && m_dump));
        check("memaddr", MemAddr,         m_alu);
        check("memdata", MemDataIn,       m_rt);
        check("wbvalid", 16'(WbValid),    16'(m_wbv));
        check("wbregwr", 16'(WbRegWrite), 16'(m_wbv && m_wbrw));
        check("halt",    16'(Halt),       16'(m_halted));
        check("err",     16'(Err),        16'(m_errored));
        if (m_wbv) begin
            check("wbdata", WbData,        m_wbd);
            check("wbrd",   16'(WbRdAddr), 16'(m_wbrd));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int stuck;
        model_reset();
        no_resp = 0;
        rst = 1; mem_done = 0; mem_data_out = '0;
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        @(negedge clk);
        tick();
        check("rst_stall", 16'(StallOut), 16'h0);
        check("rst_wbv",   16'(WbValid),  16'h0);
        check("rst_addr",  MemAddr,       16'h0);
        rst = 0;

        // ADD: writeback one cycle after capture
        set_bundle(1, 16'h1234, 16'h0, 1, 0, 0, 0, 0, 3'd3);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        tick();
        check("add_wbv",  16'(WbValid),  16'h1);
        check("add_wbd",  WbData,        16'h1234);
        check("add_rd",   16'(WbRdAddr), 16'h3);

        // LD 0x0040, data after three wait cycles; next bundle held meanwhile
        set_bundle(1, 16'h0040, 16'h0, 1, 0, 1, 1, 0, 3'd5);
        tick();
        check("ld_memrd", 16'(MemRd), 16'h1);
        set_bundle(1, 16'h5555, 16'h0, 1, 0, 0, 0, 0, 3'd1);
        tick(); check("ld_stall1", 16'(StallOut), 16'h1);
        tick(); check("ld_stall2", 16'(StallOut), 16'h1);
        tick(); check("ld_stall3", 16'(StallOut), 16'h1);
        mem_done = 1; mem_data_out = 16'hBEEF;
        tick();
        mem_done = 0;
        check("ld_wbd",    WbData,          16'hBEEF);
        check("ld_stall0", 16'(StallOut),   16'h0);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        tick();
        check("add2_wbd", WbData, 16'h5555);

        // ST 0x0010 <- 0x00AA
        set_bundle(1, 16'h0010, 16'h00AA, 0, 1, 1, 0, 0, 3'd2);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        check("st_memwr", 16'(MemWr), 16'h1);
        check("st_addr",  MemAddr,    16'h0010);
        check("st_data",  MemDataIn,  16'h00AA);
        tick();
        mem_done = 1;
        tick();
        mem_done = 0;
        check("st_wbv",  16'(WbValid),    16'h1);
        check("st_wbrw", 16'(WbRegWrite), 16'h0);

        // Misaligned load
        set_bundle(1, 16'h0041, 16'h0, 1, 0, 1, 1, 0, 3'd4);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        check("mis_memrd", 16'(MemRd), 16'h0);
        tick(); tick(); tick();
        check("mis_err",   16'(Err),      16'h1);
        check("mis_stall", 16'(StallOut), 16'h1);
        rst = 1; tick(); rst = 0;

        // Timeout: error after MAX_WAIT+1 wait cycles
        set_bundle(1, 16'h0040, 16'h0, 1, 0, 1, 1, 0, 3'd4);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < MAX_WAIT + 1; i++) tick();
        check("to_err_pre", 16'(Err), 16'h0);
        tick();
        check("to_err", 16'(Err), 16'h1);
        rst = 1; tick(); rst = 0;

        // Reset during WAIT, then a late mem_done
        set_bundle(1, 16'h0080, 16'h0, 1, 0, 1, 1, 0, 3'd6);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        tick(); tick();
        rst = 1; tick(); rst = 0;
        mem_done = 1; tick(); mem_done = 0;
        tick();
        check("late_wbv", 16'(WbValid), 16'h0);

        // HALT with DMemEn also set
        set_bundle(1, 16'h0040, 16'h0, 0, 0, 1, 0, 1, 3'd0);
        tick();
        set_bundle(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0);
        check("halt_dump",  16'(MemDump), 16'h1);
        check("halt_memrd", 16'(MemRd),   16'h0);
        tick(); tick();
        check("halt_sticky", 16'(Halt),     16'h1);
        check("halt_stall",  16'(StallOut), 16'h1);
        rst = 1; tick(); rst = 0;

        // Randomized traffic
        stuck = 0;
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] a;
            stuck = (m_halted || m_errored) ? stuck + 1 : 0;
            rst = (stuck > 4) || ($urandom_range(0, 299) == 0);
            a = 16'($urandom);
            a[0] = ($urandom_range(0, 14) == 0);
            set_bundle($urandom_range(0, 4) != 0, a, 16'($urandom), 1'($urandom),
                       1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
                       $urandom_range(0, 149) == 0, 3'($urandom));
            if (m_waiting) mem_done = !no_resp && ($urandom_range(0, 3) == 0);
            else           mem_done = ($urandom_range(0, 7) == 0);
            mem_data_out = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
